inst_fetch_unit: RTL and testbench

- Program-counter sequencer and fetch buffer placed in front of the combinational, byte-addressed, little-endian instruction memory.
- Drives the 64-bit instruction address each cycle and captures the returned 32-bit word with its PC into a small FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects (with flush) and a halt request.

---
 rtl/inst_fetch_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Program-counter sequencer and small fetch buffer that sits in front of a
// combinational, byte-addressed, little-endian instruction memory. Each cycle
// the current pc is driven on inst_address. When the fetch buffer can accept
// an entry, the returned word is captured together with its pc, and pc
// advances by PC_STEP. Decode drains the buffer over a valid/ready handshake.
//
// Redirects flush the buffer and load a new (word-aligned) pc. A halt request
// stops fetching until the next redirect.
//
// Parameters:
//   RESET_PC        pc value loaded by reset
//   DEPTH           fetch buffer entries (power of two, >= 2)
//   PC_STEP         byte increment per sequential fetch
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   inst_address    address to instruction memory (always the internal pc)
//   instruction     memory read data, combinational from inst_address
//   redirect_valid  load redirect_pc this cycle and flush the buffer
//   redirect_pc     redirect target (bits [1:0] are dropped)
//   halt_req        stop fetching (sampled every cycle)
//   out_valid       buffer head valid
//   out_ready       consumer accepts the head
//   out_instruction head instruction
//   out_pc          head pc
//   halted          in HALT and buffer empty
//   misalign_err    sticky; a redirect target had nonzero low bits
//   fetch_count     instructions pushed since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  // Redirect targets are forced onto a 4-byte boundary.
  function automatic logic [63:0] align_pc(input logic [63:0] target);
    return {target[63:2], 2'b00};
  endfunction

  // Sequential pc step; 64-bit unsigned, wraps silently past 2^64.
  function automatic logic [63:0] step_pc(input logic [63:0] pc);
    return pc + PC_STEP;
  endfunction

  // DEPTH is a power of two, so the natural pointer overflow is the wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      fcount_q, fcount_d;

  // Buffer storage: instruction word and its pc per entry.
  logic [31:0]      inst_mem_q [DEPTH];
  logic [63:0]      pc_mem_q   [DEPTH];

  logic             push;
  logic             pop;
  logic             buf_empty;
  logic             buf_full;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == DEPTH_C);

  // A pop is a completed handshake; it is legal even in a redirect cycle
  // (the flush makes the popped entry irrelevant to the new stream).
  assign pop = !buf_empty && out_ready;

  // A full buffer can still accept a push when the head leaves that cycle.
  assign push = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                (!buf_full || pop);

  // ---------------------------------------------------------------------------
  // Run/halt FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect wins over halt in the same cycle; HALT only leaves on redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!redirect_valid && halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state for pc, pointers, occupancy and status
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    fcount_d   = fcount_q;

    if (redirect_valid) begin
      // Flush: everything in flight belongs to the abandoned path.
      pc_d     = align_pc(redirect_pc);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        pc_d     = step_pc(pc_q);
        wr_ptr_d = ptr_inc(wr_ptr_q);
        fcount_d = fcount_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      fcount_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      fcount_q   <= fcount_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage. Cleared on reset so the head reads as zero afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= instruction;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all registered, no path from instruction to out_*.
  // ---------------------------------------------------------------------------
  assign inst_address    = pc_q;
  assign out_valid       = !buf_empty;
  assign out_instruction = inst_mem_q[rd_ptr_q];
  assign out_pc          = pc_mem_q[rd_ptr_q];
  assign halted          = (state_q == ST_HALT) && buf_empty;
  assign misalign_err    = misalign_q;
  assign fetch_count     = fcount_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  inst_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2), .PC_STEP(64'd4)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_address   (inst_address),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two preloaded words, a deterministic hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00200293;
    if (a == 64'h4) return 32'h10503023;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  assign instruction = mem_word(inst_address);

  // Reference model: a queue of fetched {pc, word} plus a few scalars.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_running;
  bit          m_err;
  logic [31:0] m_fc;
  localparam int MDEPTH = 2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the rules of one clock edge to the model, using the inputs in force.
  task automatic model_edge();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_pc      = 64'h0;
      m_running = 1'b1;
      m_err     = 1'b0;
      m_fc      = 32'd0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc      = {redirect_pc[63:2], 2'b00};
      m_running = 1'b1;
      if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = m_running && !halt_req && ((mq.size() < MDEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc  = m_pc;
        e.ins = mem_word(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
        m_fc = m_fc + 32'd1;
      end
      if (m_running && halt_req) m_running = 1'b0;
    end
  endtask

  task automatic check_model();
    check("addr", inst_address, m_pc);
    check("valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_ins", {32'd0, out_instruction}, {32'd0, mq[0].ins});
    end
    check("halted", {63'd0, halted}, {63'd0, (!m_running && mq.size() == 0)});
    check("misalign", {63'd0, misalign_err}, {63'd0, m_err});
    check("fcount", {32'd0, fetch_count}, {32'd0, m_fc});
  endtask

  // Drive one cycle of inputs, advance a clock edge, then compare.
  task automatic step(input logic rst_n, input logic rv, input logic [63:0] rpc,
                      input logic hr, input logic rdy);
    reset          = rst_n;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    out_ready      = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  logic [63:0] frozen_addr;
  logic [63:0] rpc_r;

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b1;
    m_pc = '0; m_running = 1'b1; m_err = 1'b0; m_fc = '0;

    // Reset values
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_ins", {32'd0, out_instruction}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_err", {63'd0, misalign_err}, 64'd0);
    check("rst_fc", {32'd0, fetch_count}, 64'd0);
    check("rst_addr", inst_address, 64'd0);

    // Streaming with out_ready held high
    step(1, 0, 0, 0, 1);
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_pc", out_pc, 64'h0);
    check("first_ins", {32'd0, out_instruction}, 64'h00200293);
    step(1, 0, 0, 0, 1);
    check("second_pc", out_pc, 64'h4);
    check("second_ins", {32'd0, out_instruction}, 64'h10503023);
    check("second_fc", {32'd0, fetch_count}, 64'd2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    check("stream_pc", out_pc, 64'h14);

    // Back-pressure after reset: fill to DEPTH, pc freezes
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    check("full_addr", inst_address, 64'h8);
    check("full_fc", {32'd0, fetch_count}, 64'd2);
    check("full_head", out_pc, 64'h0);
    step(1, 0, 0, 0, 1);
    check("drain1_pc", out_pc, 64'h4);
    step(1, 0, 0, 0, 1);
    check("drain2_pc", out_pc, 64'h8);

    // Redirect to 0x2C with PCs 8 and 12 buffered
    step(1, 0, 0, 0, 0);
    check("pre_redir_pc", out_pc, 64'h8);
    step(1, 1, 64'h2C, 0, 0);
    check("redir_valid", {63'd0, out_valid}, 64'd0);
    check("redir_addr", inst_address, 64'h2C);
    step(1, 0, 0, 0, 0);
    check("redir_tgt", out_pc, 64'h2C);
    step(1, 0, 0, 0, 1);
    check("redir_next", out_pc, 64'h30);

    // Misaligned redirect; flag is sticky
    step(1, 1, 64'h2E, 0, 1);
    check("mis_err", {63'd0, misalign_err}, 64'd1);
    check("mis_addr", inst_address, 64'h2C);
    step(1, 0, 0, 0, 1);
    check("mis_pc", out_pc, 64'h2C);
    step(1, 1, 64'h100, 0, 1);
    check("mis_sticky", {63'd0, misalign_err}, 64'd1);

    // Halt with two entries queued, then drain
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    check("halt_hold", {63'd0, halted}, 64'd0);
    step(1, 0, 0, 0, 1);
    check("halt_pop1", out_pc, 64'h104);
    step(1, 0, 0, 0, 1);
    check("halt_empty", {63'd0, out_valid}, 64'd0);
    check("halted", {63'd0, halted}, 64'd1);
    frozen_addr = inst_address;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      check("halt_addr", inst_address, frozen_addr);
    end
    step(1, 1, 64'h0, 0, 1);
    check("unhalt", {63'd0, halted}, 64'd0);
    check("unhalt_addr", inst_address, 64'h0);
    step(1, 0, 0, 0, 1);
    check("unhalt_pc", out_pc, 64'h0);

    // Reset mid-stream with a full buffer and halt_req asserted
    step(1, 0, 0, 0, 0);
    check("pre_rst_full", out_pc, 64'h0);
    step(0, 0, 0, 1, 0);
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_pc", out_pc, 64'd0);
    check("mrst_ins", {32'd0, out_instruction}, 64'd0);
    check("mrst_addr", inst_address, 64'd0);
    check("mrst_err", {63'd0, misalign_err}, 64'd0);
    step(1, 0, 0, 0, 1);
    check("mrst_restart", out_pc, 64'h0);

    // pc wrap past 2^64
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("wrap_addr", inst_address, 64'h0);
    check("wrap_head", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rpc_r = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc_r = {60'hFFFF_FFFF_FFFF_FFF, rpc_r[3:0]};
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 15) == 0),
           rpc_r,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
